// File: rtl/stm_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stm_timing_pkg
// Brief    : Shared VGA line-timing encodings and defaults (generator + rx).
// Revision : 1.0
// ============================================================================
package stm_timing_pkg;

    localparam int STM_CNT_W     = 11;
    localparam int STM_DISP_LEN  = 1280;
    localparam int STM_FRONT_LEN = 48;
    localparam int STM_SYNC_LEN  = 112;
    localparam int STM_BACK_LEN  = 248;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_DISP  = 3'd1,
        PH_FRONT = 3'd2,
        PH_SYNC  = 3'd3,
        PH_BACK  = 3'd4
    } phase_e;

    // Sync is active low, so sync asserted during display is the illegal combo.
    function automatic logic stm_proto_bad(input logic sync_n, input logic disp);
        return disp & ~sync_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stm_timing_rx_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : stm_sat_cnt
// Brief    : Saturating phase counter with clear, load-1 and increment.
// Revision : 1.0
// ============================================================================
module stm_sat_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat;

    assign sat = (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_load1) begin
            cnt_d = CNT_W'(1);
        end else if (i_inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_sat = sat;

endmodule
`default_nettype wire

// File: rtl/stm_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : stm_timing_rx
// Brief    : VGA line-timing receiver: measures phase lengths, locks, flags
//            protocol errors. Optional pixel counter under STM_RX_PIX_X_EN.
// Revision : 1.0
// ============================================================================
module stm_timing_rx
    import stm_timing_pkg::*;
#(
    parameter int CNT_W      = STM_CNT_W,
    parameter int LOCK_LINES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sync,
    input  logic             i_disp,
    output logic [CNT_W-1:0] o_disp_len,
    output logic [CNT_W-1:0] o_front_len,
    output logic [CNT_W-1:0] o_sync_len,
    output logic [CNT_W-1:0] o_back_len,
    output logic             o_line_done,
    output logic             o_locked,
    output logic             o_err
`ifdef STM_RX_PIX_X_EN
    ,
    output logic [CNT_W-1:0] o_pix_x,
    output logic             o_pix_valid
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_LINES);

    logic             s_sync_q, s_sync_d;
    logic             s_disp_q, s_disp_d;
    logic             s_disp_p_q, s_disp_p_d;
    phase_e           state_q, state_d;
    logic [CNT_W-1:0] meas_disp_q, meas_disp_d;
    logic [CNT_W-1:0] meas_front_q, meas_front_d;
    logic [CNT_W-1:0] meas_sync_q, meas_sync_d;
    logic [CNT_W-1:0] pub_disp_q, pub_disp_d;
    logic [CNT_W-1:0] pub_front_q, pub_front_d;
    logic [CNT_W-1:0] pub_sync_q, pub_sync_d;
    logic [CNT_W-1:0] pub_back_q, pub_back_d;
    logic [3:0]       match_q, match_d;
    logic             locked_q, locked_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;
    logic             err;
    logic             line_end;
    logic             same;

    stm_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (state_d == PH_IDLE),
        .i_load1 (state_d != state_q),
        .i_inc   (state_q != PH_IDLE),
        .o_cnt   (cnt),
        .o_sat   (cnt_sat)
    );

    always_comb begin
        s_sync_d   = i_sync;
        s_disp_d   = i_disp;
        s_disp_p_d = s_disp_q;
        state_d    = state_q;
        err        = stm_proto_bad(s_sync_q, s_disp_q) | cnt_sat;
        case (state_q)
            PH_IDLE:  if (s_disp_q && !s_disp_p_q) state_d = PH_DISP;
            PH_DISP: begin
                // Leaving display straight into sync skips the front porch.
                if (!s_disp_q) begin
                    if (s_sync_q) state_d = PH_FRONT;
                    else          err     = 1'b1;
                end
            end
            PH_FRONT: begin
                if (s_disp_q)       err     = 1'b1;
                else if (!s_sync_q) state_d = PH_SYNC;
            end
            PH_SYNC: begin
                if (s_disp_q)      err     = 1'b1;
                else if (s_sync_q) state_d = PH_BACK;
            end
            PH_BACK:  if (s_disp_q) state_d = PH_DISP;
            default:  state_d = PH_IDLE;
        endcase
        if (err) state_d = PH_IDLE;

        line_end     = (state_q == PH_BACK) && (state_d == PH_DISP);
        meas_disp_d  = (state_q == PH_DISP  && state_d == PH_FRONT) ? cnt : meas_disp_q;
        meas_front_d = (state_q == PH_FRONT && state_d == PH_SYNC)  ? cnt : meas_front_q;
        meas_sync_d  = (state_q == PH_SYNC  && state_d == PH_BACK)  ? cnt : meas_sync_q;

        // The back length is still in the counter on the closing edge.
        same = (meas_disp_q == pub_disp_q) && (meas_front_q == pub_front_q) &&
               (meas_sync_q == pub_sync_q) && (cnt == pub_back_q);

        pub_disp_d  = pub_disp_q;
        pub_front_d = pub_front_q;
        pub_sync_d  = pub_sync_q;
        pub_back_d  = pub_back_q;
        match_d     = match_q;
        locked_d    = locked_q;
        done_d      = line_end;
        err_d       = err;
        if (err) begin
            match_d  = '0;
            locked_d = 1'b0;
        end else if (line_end) begin
            pub_disp_d  = meas_disp_q;
            pub_front_d = meas_front_q;
            pub_sync_d  = meas_sync_q;
            pub_back_d  = cnt;
            if (same) match_d = (match_q >= LOCK_N) ? match_q : match_q + 4'd1;
            else      match_d = '0;
            locked_d = (match_d == LOCK_N);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync_q     <= 1'b1;
            s_disp_q     <= 1'b0;
            s_disp_p_q   <= 1'b0;
            state_q      <= PH_IDLE;
            meas_disp_q  <= '0;
            meas_front_q <= '0;
            meas_sync_q  <= '0;
            pub_disp_q   <= '0;
            pub_front_q  <= '0;
            pub_sync_q   <= '0;
            pub_back_q   <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            s_sync_q     <= s_sync_d;
            s_disp_q     <= s_disp_d;
            s_disp_p_q   <= s_disp_p_d;
            state_q      <= state_d;
            meas_disp_q  <= meas_disp_d;
            meas_front_q <= meas_front_d;
            meas_sync_q  <= meas_sync_d;
            pub_disp_q   <= pub_disp_d;
            pub_front_q  <= pub_front_d;
            pub_sync_q   <= pub_sync_d;
            pub_back_q   <= pub_back_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_disp_len  = pub_disp_q;
    assign o_front_len = pub_front_q;
    assign o_sync_len  = pub_sync_q;
    assign o_back_len  = pub_back_q;
    assign o_line_done = done_q;
    assign o_locked    = locked_q;
    assign o_err       = err_q;

`ifdef STM_RX_PIX_X_EN
    logic [CNT_W-1:0] pix_x_q, pix_x_d;

    always_comb begin
        pix_x_d = pix_x_q;
        if (state_d == PH_DISP) begin
            pix_x_d = (state_q == PH_DISP) ? pix_x_q + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_x_q <= '0;
        else        pix_x_q <= pix_x_d;
    end

    assign o_pix_x     = pix_x_q;
    assign o_pix_valid = (state_q == PH_DISP);
`endif

endmodule
`default_nettype wire
